// File: rtl/clock_phase_tracker_if.sv
// Divided-clock input and recovered phase/lock outputs of clock_phase_tracker.
// master drives the divided clock and observes the strobes; slave is the tracker.
interface clock_phase_tracker_if #(
  parameter int PERIOD_W = 8
);
  logic                i_clk_div;
  logic                o_rise;
  logic                o_fall;
  logic [PERIOD_W-1:0] o_phase;
  logic [PERIOD_W-1:0] o_period;
  logic                o_locked;
  logic                o_pre_rise;
  logic                o_error;

  modport master (
    output i_clk_div,
    input  o_rise, o_fall, o_phase, o_period, o_locked, o_pre_rise, o_error
  );

  modport slave (
    input  i_clk_div,
    output o_rise, o_fall, o_phase, o_period, o_locked, o_pre_rise, o_error
  );
endinterface

// File: rtl/clock_phase_tracker.sv
// Tracks a divided clock in the master domain: edge strobes, period measurement, lock, rise prediction.
// Strobes appear the cycle after edge k+SYNC_STAGES for a transition first sampled at edge k.
module clock_phase_tracker #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 8,
  parameter int LOCK_COUNT  = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  clock_phase_tracker_if.slave  bus
);
  localparam int MW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  state_t                 state_q, state_d;
  logic [PERIOD_W-1:0]    phase_q, phase_d;
  logic [PERIOD_W-1:0]    period_q, period_d;
  logic [MW-1:0]          match_q, match_d;
  logic                   rise_q, fall_q, locked_q, pre_rise_q, error_q;
  logic                   error_d, pre_rise_d;
  logic                   s, rise_det, fall_det, phase_sat;
  logic [PERIOD_W-1:0]    meas_p;

  always_comb begin
    s         = sync_q[SYNC_STAGES-1];
    rise_det  = s & ~s_dly_q;
    fall_det  = ~s & s_dly_q;
    phase_sat = &phase_q;
    meas_p    = phase_q + 1'b1;

    state_d  = state_q;
    period_d = period_q;
    match_d  = match_q;
    error_d  = 1'b0;

    if (rise_det)       phase_d = '0;
    else if (phase_sat) phase_d = phase_q;
    else                phase_d = phase_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rise_det) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (rise_det) begin
          if (meas_p == period_q) begin
            match_d = match_q + 1'b1;
          end else begin
            period_d = meas_p;
            match_d  = MW'(1);
          end
          if (match_d == MW'(LOCK_COUNT)) state_d = ST_LOCKED;
        end else if (phase_sat) begin
          state_d  = ST_IDLE;
          period_d = '0;
          match_d  = '0;
          error_d  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (rise_det) begin
          if (meas_p != period_q) begin
            period_d = meas_p;
            match_d  = MW'(1);
            state_d  = ST_MEASURE;
            error_d  = 1'b1;
          end
        end else if (phase_sat) begin
          state_d  = ST_IDLE;
          period_d = '0;
          match_d  = '0;
          error_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Built from next-state values so the flag lines up with the phase it predicts.
    pre_rise_d = (state_d == ST_LOCKED) && (phase_d == period_d - 1'b1);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q     <= '0;
      s_dly_q    <= 1'b0;
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      period_q   <= '0;
      match_q    <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      locked_q   <= 1'b0;
      pre_rise_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.i_clk_div};
      s_dly_q    <= s;
      state_q    <= state_d;
      phase_q    <= phase_d;
      period_q   <= period_d;
      match_q    <= match_d;
      rise_q     <= rise_det;
      fall_q     <= fall_det;
      locked_q   <= (state_d == ST_LOCKED);
      pre_rise_q <= pre_rise_d;
      error_q    <= error_d;
    end
  end

  assign bus.o_rise     = rise_q;
  assign bus.o_fall     = fall_q;
  assign bus.o_phase    = phase_q;
  assign bus.o_period   = period_q;
  assign bus.o_locked   = locked_q;
  assign bus.o_pre_rise = pre_rise_q;
  assign bus.o_error    = error_q;
endmodule

// File: tb/tb_clock_phase_tracker.sv
// Directed and randomized divided-clock waveforms checked every cycle against an edge-history reference.
module tb_clock_phase_tracker;
  localparam int S          = 2;
  localparam int PERIOD_W   = 8;
  localparam int LOCK_COUNT = 3;
  localparam int NMAX       = 8192;
  localparam int SAT        = (1 << PERIOD_W) - 1;
  localparam int M_IDLE = 0, M_MEAS = 1, M_LOCK = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clock_phase_tracker_if #(.PERIOD_W(PERIOD_W)) bus ();

  clock_phase_tracker #(
    .SYNC_STAGES(S),
    .PERIOD_W   (PERIOD_W),
    .LOCK_COUNT (LOCK_COUNT)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic xh [NMAX];
  int   last_rise, m_period, m_match, m_mode, m_phase;
  logic m_rise, m_fall, m_pre, m_err;

  function automatic logic hx(input int i);
    return (i < 0) ? 1'b0 : xh[i];
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: the tracked level seen at edge m is the input sampled S edges earlier.
  task automatic model_edge(input logic div, input logic r);
    int  el, old_phase, p;
    bit  timeout;
    if (r) begin
      for (int j = cyc - S; j <= cyc; j++) if (j >= 0) xh[j] = 1'b0;
      last_rise = cyc; m_period = 0; m_match = 0; m_mode = M_IDLE; m_phase = 0;
      m_rise = 0; m_fall = 0; m_pre = 0; m_err = 0;
    end else begin
      xh[cyc]   = div;
      m_rise    = hx(cyc - S) && !hx(cyc - S - 1);
      m_fall    = !hx(cyc - S) && hx(cyc - S - 1);
      el        = cyc - last_rise;
      old_phase = sat(el - 1);
      p         = el;
      timeout   = !m_rise && (m_mode != M_IDLE) && (old_phase == SAT);
      m_err     = 0;
      if (m_rise) begin
        if (m_mode == M_IDLE) m_mode = M_MEAS;
        else if (m_mode == M_MEAS) begin
          if (p == m_period) m_match++;
          else begin m_period = p; m_match = 1; end
          if (m_match == LOCK_COUNT) m_mode = M_LOCK;
        end else if (p != m_period) begin
          m_period = p; m_match = 1; m_mode = M_MEAS; m_err = 1;
        end
        last_rise = cyc;
      end else if (timeout) begin
        m_mode = M_IDLE; m_period = 0; m_match = 0; m_err = 1;
      end
      m_phase = sat(cyc - last_rise);
      m_pre   = (m_mode == M_LOCK) && (m_phase == m_period - 1);
    end
    cyc++;
  endtask

  task automatic tick(input logic div, input logic r);
    bus.i_clk_div = div;
    rst           = r;
    @(posedge clk);
    model_edge(div, r);
    @(negedge clk);
    chk("rise",     bus.o_rise,     m_rise);
    chk("fall",     bus.o_fall,     m_fall);
    chk("phase",    bus.o_phase,    m_phase);
    chk("period",   bus.o_period,   m_period);
    chk("locked",   bus.o_locked,   m_mode == M_LOCK);
    chk("pre_rise", bus.o_pre_rise, m_pre);
    chk("error",    bus.o_error,    m_err);
  endtask

  task automatic gen(input int hi, input int lo, input int reps);
    for (int k = 0; k < reps; k++) begin
      for (int i = 0; i < hi; i++) tick(1'b1, 1'b0);
      for (int i = 0; i < lo; i++) tick(1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.i_clk_div = 1'b0;
    rst           = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    chk("rst_rise",   bus.o_rise,   0);
    chk("rst_locked", bus.o_locked, 0);
    chk("rst_phase",  bus.o_phase,  0);
    chk("rst_period", bus.o_period, 0);
    chk("rst_error",  bus.o_error,  0);

    // Latency: step sampled at edge k -> o_rise only in the cycle after edge k+2
    tick(1'b1, 1'b0); chk("lat_k0", bus.o_rise, 0);
    tick(1'b1, 1'b0); chk("lat_k1", bus.o_rise, 0);
    tick(1'b1, 1'b0); chk("lat_k2", bus.o_rise, 1);
    tick(1'b1, 1'b0); chk("lat_k3", bus.o_rise, 0);
    gen(2, 6, 1);

    // Lock acquisition at period 12
    gen(6, 6, 7);
    chk("lock12_locked", bus.o_locked, 1);
    chk("lock12_period", bus.o_period, 12);

    // Lock loss on a 16-cycle period, then relock at 12
    gen(6, 10, 1);
    gen(6, 6, 4);
    chk("relock_locked", bus.o_locked, 1);
    chk("relock_period", bus.o_period, 12);

    // Timeout while locked
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b0);
    chk("to_phase",  bus.o_phase,  SAT);
    chk("to_period", bus.o_period, 0);
    chk("to_locked", bus.o_locked, 0);

    // Fast divider ratios
    gen(2, 2, 6);
    chk("p4_locked", bus.o_locked, 1);
    chk("p4_period", bus.o_period, 4);
    gen(1, 1, 6);
    chk("p2_locked", bus.o_locked, 1);
    chk("p2_period", bus.o_period, 2);

    // Reset mid-lock with the divided clock high
    gen(6, 6, 5);
    chk("pre_rst_locked", bus.o_locked, 1);
    tick(1'b1, 1'b1);
    chk("mid_rst_locked",   bus.o_locked,   0);
    chk("mid_rst_period",   bus.o_period,   0);
    chk("mid_rst_pre_rise", bus.o_pre_rise, 0);
    gen(5, 6, 1);
    gen(6, 6, 2);

    // Randomized bursts of repeated periods
    for (int b = 0; b < 12; b++) begin
      gen(int'($urandom_range(1, 20)), int'($urandom_range(1, 20)), int'($urandom_range(1, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
